rr_arbiter: RTL

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/xbar_pkg.sv | 14 +
 rtl/rr_pick.sv | 33 +++
 rtl/rr_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: arbiter state encoding and index helper.
package xbar_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Increment an index, wrapping to 0 after n-1 (works for non-power-of-2 n).
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set bit of req_i at or above ptr_i, wrapping.
//   req_i     : request vector
//   ptr_i     : search start index (expected < N)
//   found_c_o : some request is set
//   idx_c_o   : index of the selected request (0 when none)
module rr_pick #(
  parameter  int unsigned N = 2,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_c_o,
  output logic [W-1:0] idx_c_o
);

  int unsigned cand;

  // Scan from the farthest candidate down so the nearest one wins.
  always_comb begin
    found_c_o = 1'b0;
    idx_c_o   = '0;
    cand      = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = 32'(ptr_i) + 32'(i);
      if (cand >= N) cand = cand - N;
      if (cand < N && req_i[W'(cand)]) begin
        found_c_o = 1'b1;
        idx_c_o   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Per-slave-port round-robin packet arbiter with registered grant.
//   clk_i, rst_n_i : clock, async active-low reset
//   req_i          : per-source request (dest match AND valid)
//   s_last_i       : per-source last-beat flag
//   m_ready_i      : downstream ready
//   grant_o        : one-hot grant, zero when idle
//   grant_idx_o    : binary index of granted source, zero when idle
//   busy_o         : a packet currently owns the port
module rr_arbiter
  import xbar_pkg::*;
#(
  parameter  int unsigned S_DATA_COUNT = 2,
  localparam int unsigned S_IDX_WIDTH  = $clog2(S_DATA_COUNT)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [S_DATA_COUNT-1:0] req_i,
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  input  logic                    m_ready_i,
  output logic [S_DATA_COUNT-1:0] grant_o,
  output logic [S_IDX_WIDTH-1:0]  grant_idx_o,
  output logic                    busy_o
);

  arb_state_t              state_q, state_d;
  logic [S_IDX_WIDTH-1:0]  ptr_q, ptr_d;
  logic [S_DATA_COUNT-1:0] grant_q, grant_d;
  logic [S_IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                    busy_q, busy_d;

  logic                    pick_found;
  logic [S_IDX_WIDTH-1:0]  pick_idx;
  logic                    beat_acc;
  logic                    pkt_end;

  rr_pick #(.N(S_DATA_COUNT)) u_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .found_c_o (pick_found),
    .idx_c_o   (pick_idx)
  );

  assign beat_acc = req_i[idx_q] & m_ready_i;
  assign pkt_end  = beat_acc & s_last_i[idx_q];

  // State, pointer and grant registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: grant on request in idle, hold until the last beat is accepted.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BUSY;
          grant_d = S_DATA_COUNT'(1) << pick_idx;
          idx_d   = pick_idx;
          busy_d  = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (pkt_end) begin
          state_d = ARB_IDLE;
          ptr_d   = S_IDX_WIDTH'(wrap_inc(32'(idx_q), S_DATA_COUNT));
          grant_d = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign busy_o      = busy_q;

endmodule
